controlador_trama: RTL and testbench
====================================

Name: controlador_trama

Overview:
Frame controller that sequences reception of plant configuration over the UART receive path. Consumes bytes from the rx block as ASCII characters and locates a framed command "#HHHhhmmP\n": start marker, 3 humidity digits, 4 time digits (hh mm), 1 plant-type digit, terminator. Validates characters and ranges, times out stalled frames, and commits humidity/time/plant-type to the control logic atomically, with a single-cycle completion strobe.

Parameters:
TIMEOUT_CICLOS, 24'd5_000_000, max clk cycles between accepted bytes inside a frame before abort
NUM_PLANTAS, 4'd10, number of valid plant types; accepted type digit is 0..NUM_PLANTAS-1
CAR_INICIO, 8'h23, start marker ('#')
CAR_FIN, 8'h0A, terminator ('\n')

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
hecho  input  1  rx byte-done flag, synchronous to clk, may stay high several cycles; rising edge = new byte
dato  input  8  rx byte, stable while hecho high
humedad  output  12  committed humidity, BCD c-d-u
hora  output  16  committed time, BCD h h m m
tipoPlanta  output  4  committed plant type
config_valida  output  1  high once any frame has committed
listo  output  1  one-cycle pulse on commit
error  output  1  one-cycle pulse on frame abort
cod_error  output  2  cause of last abort: 0 none, 1 bad character, 2 out of range, 3 timeout

Behaviour:
- Reset (async, rst_n=0): humedad=0, hora=0, tipoPlanta=0, config_valida=0, listo=0, error=0, cod_error=0, state ESPERA, index=0, timer=0, hecho edge flop=0.
- Byte event: edge N samples hecho=1 while previous sample=0; dato captured and processed at edge N. Level-high hecho produces exactly one event.
- Digit = dato in 8'h30..8'h39; value = dato[3:0]. Digits collected into shadow registers, never directly into outputs.
- ESPERA: all bytes except CAR_INICIO ignored, no error. CAR_INICIO -> DIGITOS, index=0, timer=0.
- DIGITOS: digit -> shadow[index], index+1; 8th digit -> FIN. CAR_INICIO -> restart (index=0, timer=0), no error. Any other byte -> abort code 1.
- FIN: CAR_FIN -> range check; any other byte (including digits) -> abort code 1.
- Range check (same edge as terminator): humidity <= 100 (hundreds digit 0, or exactly 1,0,0); hours <= 23; minutes <= 59; plant type < NUM_PLANTAS. Pass -> commit; fail -> abort code 2.
- Commit: edge N+1 after terminator edge N: outputs load from shadow, config_valida=1, listo=1 for one cycle, cod_error=0, state ESPERA.
- Abort: error=1 for one cycle on edge N+1, cod_error updated and held until next commit/abort, outputs unchanged, state ESPERA.
- Timeout: in DIGITOS/FIN, timer increments each cycle and clears on each byte event; timer reaching TIMEOUT_CICLOS-1 -> abort code 3. Never counts in ESPERA.
- listo and error never high in the same cycle; byte event on the commit/abort cycle is processed normally in ESPERA.
- Reset mid-frame: partial frame discarded, outputs cleared per reset values.

Test Plan:
- Reset then "#04513072\n" -> listo one cycle; humedad=12'h045, hora=16'h1307, tipoPlanta=4'h2, config_valida=1, cod_error=0.
- After valid frame, "#10025003\n" (hour 25) -> error pulse, cod_error=2, humedad/hora/tipoPlanta still 045/1307/2.
- "#04A..." -> error at 'A', cod_error=1; then "xx#10000009\n" -> commit humedad=12'h100, hora=16'h0000, tipoPlanta=9.
- "#045" then idle TIMEOUT_CICLOS (set to 16 in bench) -> error, cod_error=3; idle in ESPERA for 100 cycles -> no error.
- "#0451#05512345\n" with hecho held 3 cycles per byte -> single commit humedad=12'h055, hora=16'h1234, tipoPlanta=5; exactly one event per byte.
- rst_n low after "#0451" then release, send "3072\n" -> no listo/error; outputs at reset values.

Source files
------------

// File: rtl/controlador_trama_if.sv
// Receive-side byte handshake between the UART rx block and the frame controller.
interface controlador_trama_if;
  logic       hecho;
  logic [7:0] dato;

  modport master (output hecho, output dato);
  modport slave  (input  hecho, input  dato);
endinterface

// File: rtl/controlador_trama.sv
// Frame controller: parses "#HHHhhmmP\n" from rx bytes, range-checks it and commits
// humidity/time/plant type atomically. Aborts on bad character, bad range or timeout.
//
// state   | meaning
// ESPERA  | idle, waiting for start marker
// DIGITOS | collecting the 8 frame digits into shadow registers
// FIN     | all digits in, waiting for terminator
module controlador_trama #(
  parameter logic [23:0] TIMEOUT_CICLOS = 24'd5_000_000,
  parameter logic [3:0]  NUM_PLANTAS    = 4'd10,
  parameter logic [7:0]  CAR_INICIO     = 8'h23,
  parameter logic [7:0]  CAR_FIN        = 8'h0A
) (
  input  logic                      clk,
  input  logic                      rst_n,
  controlador_trama_if.slave        rx,
  output logic [11:0]               humedad,
  output logic [15:0]               hora,
  output logic [3:0]                tipoPlanta,
  output logic                      config_valida,
  output logic                      listo,
  output logic                      error,
  output logic [1:0]                cod_error
);

  localparam logic [1:0] ESPERA  = 2'd0;
  localparam logic [1:0] DIGITOS = 2'd1;
  localparam logic [1:0] FIN     = 2'd2;

  localparam logic [1:0] COD_CARACTER = 2'd1;
  localparam logic [1:0] COD_RANGO    = 2'd2;
  localparam logic [1:0] COD_TIEMPO   = 2'd3;

  logic [1:0]       r_estado;
  logic [2:0]       r_indice;
  logic [23:0]      r_timer;
  logic             r_hecho_prev;
  logic [7:0][3:0]  r_sombra;
  logic             r_commit_pend;
  logic             r_abort_pend;
  logic [1:0]       r_cod_pend;

  logic w_evento;
  logic w_digito;
  logic w_hum_ok;
  logic w_hora_ok;
  logic w_min_ok;
  logic w_tipo_ok;
  logic w_rango_ok;
  logic w_timeout;

  assign w_evento  = rx.hecho & ~r_hecho_prev;
  assign w_digito  = (rx.dato >= 8'h30) && (rx.dato <= 8'h39);
  assign w_timeout = (r_timer == TIMEOUT_CICLOS - 24'd1);

  // Shadow slot 0 is the hundreds digit of humidity; slot 7 is the plant type.
  assign w_hum_ok   = (r_sombra[0] == 4'd0) ||
                      ((r_sombra[0] == 4'd1) && (r_sombra[1] == 4'd0) && (r_sombra[2] == 4'd0));
  assign w_hora_ok  = (r_sombra[3] < 4'd2) || ((r_sombra[3] == 4'd2) && (r_sombra[4] <= 4'd3));
  assign w_min_ok   = (r_sombra[5] <= 4'd5);
  assign w_tipo_ok  = (r_sombra[7] < NUM_PLANTAS);
  assign w_rango_ok = w_hum_ok && w_hora_ok && w_min_ok && w_tipo_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      humedad       <= '0;
      hora          <= '0;
      tipoPlanta    <= '0;
      config_valida <= 1'b0;
      listo         <= 1'b0;
      error         <= 1'b0;
      cod_error     <= '0;
      r_estado      <= ESPERA;
      r_indice      <= '0;
      r_timer       <= '0;
      r_hecho_prev  <= 1'b0;
      r_sombra      <= '0;
      r_commit_pend <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_cod_pend    <= '0;
    end else begin
      r_hecho_prev  <= rx.hecho;
      listo         <= r_commit_pend;
      error         <= r_abort_pend;
      r_commit_pend <= 1'b0;
      r_abort_pend  <= 1'b0;

      if (r_commit_pend) begin
        humedad       <= {r_sombra[0], r_sombra[1], r_sombra[2]};
        hora          <= {r_sombra[3], r_sombra[4], r_sombra[5], r_sombra[6]};
        tipoPlanta    <= r_sombra[7];
        config_valida <= 1'b1;
        cod_error     <= 2'd0;
      end
      if (r_abort_pend) begin
        cod_error <= r_cod_pend;
      end

      // Decisions are taken on the byte edge and become visible one edge later,
      // so the FSM is already back in ESPERA when listo/error pulse.
      case (r_estado)
        ESPERA: begin
          r_timer <= '0;
          if (w_evento && (rx.dato == CAR_INICIO)) begin
            r_estado <= DIGITOS;
            r_indice <= '0;
          end
        end
        DIGITOS: begin
          if (w_evento) begin
            r_timer <= '0;
            if (w_digito) begin
              r_sombra[r_indice] <= rx.dato[3:0];
              if (r_indice == 3'd7) begin
                r_estado <= FIN;
              end else begin
                r_indice <= r_indice + 3'd1;
              end
            end else if (rx.dato == CAR_INICIO) begin
              r_indice <= '0;
            end else begin
              r_abort_pend <= 1'b1;
              r_cod_pend   <= COD_CARACTER;
              r_estado     <= ESPERA;
            end
          end else if (w_timeout) begin
            r_abort_pend <= 1'b1;
            r_cod_pend   <= COD_TIEMPO;
            r_estado     <= ESPERA;
          end else begin
            r_timer <= r_timer + 24'd1;
          end
        end
        FIN: begin
          if (w_evento) begin
            r_timer  <= '0;
            r_estado <= ESPERA;
            if (rx.dato == CAR_FIN) begin
              if (w_rango_ok) begin
                r_commit_pend <= 1'b1;
              end else begin
                r_abort_pend <= 1'b1;
                r_cod_pend   <= COD_RANGO;
              end
            end else begin
              r_abort_pend <= 1'b1;
              r_cod_pend   <= COD_CARACTER;
            end
          end else if (w_timeout) begin
            r_abort_pend <= 1'b1;
            r_cod_pend   <= COD_TIEMPO;
            r_estado     <= ESPERA;
          end else begin
            r_timer <= r_timer + 24'd1;
          end
        end
        default: begin
          r_estado <= ESPERA;
          r_timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_trama.sv
// Directed bench for controlador_trama: frames, aborts, timeout, held hecho and mid-frame reset.
module tb_controlador_trama;

  logic        clk;
  logic        rst_n;
  logic [11:0] humedad;
  logic [15:0] hora;
  logic [3:0]  tipoPlanta;
  logic        config_valida;
  logic        listo;
  logic        error;
  logic [1:0]  cod_error;

  int n_checks;
  int n_fail;
  int n_listo;
  int n_error;
  int n_ambos;

  controlador_trama_if rx_if ();

  controlador_trama #(
    .TIMEOUT_CICLOS (24'd16),
    .NUM_PLANTAS    (4'd10),
    .CAR_INICIO     (8'h23),
    .CAR_FIN        (8'h0A)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx_if.slave),
    .humedad       (humedad),
    .hora          (hora),
    .tipoPlanta    (tipoPlanta),
    .config_valida (config_valida),
    .listo         (listo),
    .error         (error),
    .cod_error     (cod_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters count high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (listo) n_listo++;
    if (error) n_error++;
    if (listo && error) n_ambos++;
  end

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic enviar_byte(input logic [7:0] b, input int hold);
    rx_if.dato  = b;
    rx_if.hecho = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_if.hecho = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic enviar_trama(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) enviar_byte(s[i], hold);
  endtask

  task automatic esperar(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic salidas(input string tag, input logic [11:0] h, input logic [15:0] t,
                         input logic [3:0] p, input logic cv, input logic [1:0] c);
    comprobar({tag, ".humedad"},       32'(humedad),       32'(h));
    comprobar({tag, ".hora"},          32'(hora),          32'(t));
    comprobar({tag, ".tipoPlanta"},    32'(tipoPlanta),    32'(p));
    comprobar({tag, ".config_valida"}, 32'(config_valida), 32'(cv));
    comprobar({tag, ".cod_error"},     32'(cod_error),     32'(c));
  endtask

  int l0, e0, k;

  initial begin
    n_checks = 0; n_fail = 0; n_listo = 0; n_error = 0; n_ambos = 0;
    rx_if.hecho = 1'b0;
    rx_if.dato  = 8'h00;
    rst_n = 1'b0;
    esperar(3);
    #2 rst_n = 1'b1;
    esperar(2);

    salidas("reset", 12'h000, 16'h0000, 4'h0, 1'b0, 2'd0);
    comprobar("reset.listo", 32'(listo), 32'd0);
    comprobar("reset.error", 32'(error), 32'd0);

    l0 = n_listo; e0 = n_error;
    enviar_trama("#04513072\n", 1);
    esperar(3);
    comprobar("f1.listo_pulsos", n_listo - l0, 1);
    comprobar("f1.error_pulsos", n_error - e0, 0);
    salidas("f1", 12'h045, 16'h1307, 4'h2, 1'b1, 2'd0);

    l0 = n_listo; e0 = n_error;
    enviar_trama("#10025003\n", 1);
    esperar(3);
    comprobar("rango.listo_pulsos", n_listo - l0, 0);
    comprobar("rango.error_pulsos", n_error - e0, 1);
    salidas("rango", 12'h045, 16'h1307, 4'h2, 1'b1, 2'd2);

    l0 = n_listo; e0 = n_error;
    enviar_trama("#04A", 1);
    esperar(3);
    comprobar("car.error_pulsos", n_error - e0, 1);
    salidas("car", 12'h045, 16'h1307, 4'h2, 1'b1, 2'd1);

    l0 = n_listo; e0 = n_error;
    enviar_trama("xx#10000009\n", 1);
    esperar(3);
    comprobar("f2.listo_pulsos", n_listo - l0, 1);
    comprobar("f2.error_pulsos", n_error - e0, 0);
    salidas("f2", 12'h100, 16'h0000, 4'h9, 1'b1, 2'd0);

    e0 = n_error; l0 = n_listo;
    enviar_trama("#045", 1);
    k = 0;
    while ((n_error == e0) && (k < 60)) begin
      esperar(1);
      k++;
    end
    comprobar("tiempo.detectado", 32'(k < 60), 32'd1);
    esperar(2);
    comprobar("tiempo.error_pulsos", n_error - e0, 1);
    comprobar("tiempo.listo_pulsos", n_listo - l0, 0);
    salidas("tiempo", 12'h100, 16'h0000, 4'h9, 1'b1, 2'd3);

    e0 = n_error;
    esperar(100);
    comprobar("espera.sin_error", n_error - e0, 0);
    comprobar("espera.cod_error", 32'(cod_error), 32'd3);

    l0 = n_listo; e0 = n_error;
    enviar_trama("#0451#05512345\n", 3);
    esperar(3);
    comprobar("lento.listo_pulsos", n_listo - l0, 1);
    comprobar("lento.error_pulsos", n_error - e0, 0);
    salidas("lento", 12'h055, 16'h1234, 4'h5, 1'b1, 2'd0);

    l0 = n_listo; e0 = n_error;
    enviar_trama("#0451", 1);
    rst_n = 1'b0;
    esperar(2);
    salidas("rst_medio", 12'h000, 16'h0000, 4'h0, 1'b0, 2'd0);
    #2 rst_n = 1'b1;
    esperar(2);
    enviar_trama("3072\n", 1);
    esperar(3);
    comprobar("rst_medio.listo_pulsos", n_listo - l0, 0);
    comprobar("rst_medio.error_pulsos", n_error - e0, 0);
    salidas("post_rst", 12'h000, 16'h0000, 4'h0, 1'b0, 2'd0);

    comprobar("listo_error_simultaneos", n_ambos, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
